// File: rtl/datapath_regfile.sv
// Post-ALU datapath: shifter onto the C bus, microarchitectural register set,
// A/B operand bus drive, memory/fetch return capture and latched ALU flags.
module datapath_regfile #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] SP_RESET = 32'h0000_0000,
   parameter logic [31:0] LV_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] alu_answer,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic [1:0]  shift_ctl,
   input  logic [8:0]  c_wr,
   input  logic [3:0]  b_sel,
   input  logic        mem_rd_valid,
   input  logic [31:0] mem_rd_data,
   input  logic        fetch_valid,
   input  logic [7:0]  fetch_data,
   output logic [31:0] a_bus,
   output logic [31:0] b_bus,
   output logic [31:0] c_bus,
   output logic [31:0] mar,
   output logic [31:0] mdr,
   output logic [31:0] pc,
   output logic [7:0]  mbr,
   output logic        n_flag,
   output logic        z_flag
);

   localparam int DATA_W = 32;

   logic [DATA_W-1:0] h, opc, tos, cpp, lv, sp;

   // Code 11 is illegal and falls through to pass-through.
   function automatic logic [DATA_W-1:0] shift_fn(input logic signed [DATA_W-1:0] x,
                                                  input logic [1:0] ctl);
      logic [DATA_W-1:0] r;
      case (ctl)
         2'b10:   r = {x[DATA_W-9:0], 8'h00};
         2'b01:   r = x >>> 1;
         default: r = x;
      endcase
      return r;
   endfunction

   assign c_bus = shift_fn(alu_answer, shift_ctl);
   assign a_bus = h;

   always_comb begin
      b_bus = '0;
      case (b_sel)
         4'd0:    b_bus = mdr;
         4'd1:    b_bus = pc;
         4'd2:    b_bus = {{24{mbr[7]}}, mbr};
         4'd3:    b_bus = {24'h0, mbr};
         4'd4:    b_bus = sp;
         4'd5:    b_bus = lv;
         4'd6:    b_bus = cpp;
         4'd7:    b_bus = tos;
         4'd8:    b_bus = opc;
         default: b_bus = '0;
      endcase
   end

   // Register file: C-bus writes, with memory return taking MDR over the C bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h      <= '0;
         opc    <= '0;
         tos    <= '0;
         cpp    <= '0;
         lv     <= LV_RESET;
         sp     <= SP_RESET;
         pc     <= PC_RESET;
         mdr    <= '0;
         mar    <= '0;
         mbr    <= '0;
         n_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         if (c_wr[8]) h   <= c_bus;
         if (c_wr[7]) opc <= c_bus;
         if (c_wr[6]) tos <= c_bus;
         if (c_wr[5]) cpp <= c_bus;
         if (c_wr[4]) lv  <= c_bus;
         if (c_wr[3]) sp  <= c_bus;
         if (c_wr[2]) pc  <= c_bus;
         if (mem_rd_valid)  mdr <= mem_rd_data;
         else if (c_wr[1])  mdr <= c_bus;
         if (c_wr[0]) mar <= c_bus;
         if (fetch_valid) mbr <= fetch_data;
         // Flags track the unshifted ALU result for next-cycle JAMN/JAMZ.
         n_flag <= alu_n;
         z_flag <= alu_z;
      end
   end

endmodule

// File: doc/datapath_regfile.md
Name: datapath_regfile

Overview:
- Stage directly downstream of the 32-bit ALU. Takes the ALU result through a shifter onto the C bus and writes it into the microarchitectural register set: H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR and MBR.
- Drives the ALU operand buses: A bus is always H; B bus comes from a decoded register selector.
- Latches the ALU N/Z flags for the microsequencer.
- Accepts memory read and instruction fetch returns into MDR and MBR.

Parameters:
- PC_RESET, 32'h0000_0000, reset value of PC.
- SP_RESET, 32'h0000_0000, reset value of SP.
- LV_RESET, 32'h0000_0000, reset value of LV.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- alu_answer  in  32  ALU result
- alu_n  in  1  ALU negative flag
- alu_z  in  1  ALU zero flag
- shift_ctl  in  2  {SLL8, SRA1}
- c_wr  in  9  C-bus write enables, bit8..0 = H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR
- b_sel  in  4  B-bus source select
- mem_rd_valid  in  1  memory read data valid this cycle
- mem_rd_data  in  32  memory read data
- fetch_valid  in  1  instruction byte valid this cycle
- fetch_data  in  8  fetched byte
- a_bus  out  32  = H
- b_bus  out  32  selected B source
- c_bus  out  32  shifter output
- mar  out  32  MAR register
- mdr  out  32  MDR register
- pc  out  32  PC register
- mbr  out  8  MBR register
- n_flag  out  1  latched N
- z_flag  out  1  latched Z

Behaviour:
- Shifter, combinational on alu_answer:
  - 00: pass through.
  - 10 (SLL8): {alu_answer[23:0], 8'h00}.
  - 01 (SRA1): {alu_answer[31], alu_answer[31:1]}.
  - 11: illegal, passes alu_answer unshifted.
- c_bus is the shifter output.
- Register writes, on the rising clk edge:
  - Every register whose c_wr bit is 1 loads c_bus.
  - Multiple bits set means all selected registers load the same value.
  - Registers with c_wr = 0 hold their value.
- MDR priority: mem_rd_valid=1 loads mem_rd_data into MDR and overrides c_wr[1] in the same cycle. The C-bus write to MDR is dropped; other c_wr targets still load.
- MBR:
  - Loads fetch_data when fetch_valid=1, otherwise holds.
  - MBR is not C-bus writable.
- B-bus select, combinational from register outputs (registered value, not the value being written this cycle):
  - 0 MDR
  - 1 PC
  - 2 MBR sign-extended ({{24{mbr[7]}}, mbr})
  - 3 MBRU zero-extended ({24'h0, mbr})
  - 4 SP
  - 5 LV
  - 6 CPP
  - 7 TOS
  - 8 OPC
  - 9..15 drive 32'h0
- a_bus = H, combinational.
- Flags:
  - n_flag <= alu_n and z_flag <= alu_z every clock edge, unconditionally.
  - Flags describe the ALU result of the previous cycle, with 1-cycle latency for the sequencer's JAMN/JAMZ.
  - Flags reflect the unshifted ALU result.
- Latency:
  - A register written in cycle k is visible on b_bus, a_bus and the outputs in cycle k+1.
  - Read-after-write in the same cycle returns the old value.
- Reset (rst_n=0 at a clk edge):
  - PC=PC_RESET, SP=SP_RESET, LV=LV_RESET.
  - All other registers, MBR, n_flag and z_flag = 0.
  - Reset overrides c_wr, mem_rd_valid and fetch_valid in the same cycle.
  - Reset mid-operation discards any pending write.
  - c_bus and b_bus remain combinational during reset.
- No internal state beyond the registers listed.

Test Plan:
- Reset with PC_RESET=32'h100: after rst_n low for 1 edge, pc=32'h100, mar=mdr=0, mbr=0, n_flag=z_flag=0, b_sel=1 gives b_bus=32'h100.
- alu_answer=32'h8000_00F0, shift_ctl=01, c_wr=9'h100 (H): next cycle a_bus=32'hC000_0078; with shift_ctl=10, H=32'h0000_F000.
- Write c_wr=9'h006 (PC+MDR) with c_bus=32'h1234, while mem_rd_valid=1 and mem_rd_data=32'hDEAD_BEEF: pc=32'h1234, mdr=32'hDEAD_BEEF.
- fetch_valid=1, fetch_data=8'hFE: b_sel=2 gives b_bus=32'hFFFF_FFFE, b_sel=3 gives 32'h0000_00FE, b_sel=12 gives 0.
- alu_n=1 and alu_z=0 in cycle k, alu_z=1 in cycle k+1: n_flag=1 in k+1, z_flag=1 in k+2, n_flag follows alu_n likewise.
- Assert rst_n=0 in the same cycle as c_wr=9'h1FF and c_bus=32'hFFFF_FFFF: all registers hold reset values afterwards and no write lands.
